// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared state encoding, 7-segment glyphs and BCD split for seg_countdown
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] GLYPH_0   = 7'b1000000;
    localparam logic [6:0] GLYPH_1   = 7'b1111001;
    localparam logic [6:0] GLYPH_2   = 7'b0100100;
    localparam logic [6:0] GLYPH_3   = 7'b0110000;
    localparam logic [6:0] GLYPH_4   = 7'b0011001;
    localparam logic [6:0] GLYPH_5   = 7'b0010010;
    localparam logic [6:0] GLYPH_6   = 7'b0000010;
    localparam logic [6:0] GLYPH_7   = 7'b1111000;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Weighted compare-subtract; valid for 0..99
    function automatic bcd_t bin2bcd(input logic [6:0] bin);
        logic [6:0] rem;
        bcd_t       r;
        rem    = bin;
        r.tens = 4'd0;
        if (rem >= 7'd80) begin r.tens[3] = 1'b1; rem = rem - 7'd80; end
        if (rem >= 7'd40) begin r.tens[2] = 1'b1; rem = rem - 7'd40; end
        if (rem >= 7'd20) begin r.tens[1] = 1'b1; rem = rem - 7'd20; end
        if (rem >= 7'd10) begin r.tens[0] = 1'b1; rem = rem - 7'd10; end
        r.ones = rem[3:0];
        return r;
    endfunction

endpackage

// File: rtl/seg_countdown_if.sv
// rtl/seg_countdown_if.sv - phase input and display outputs of seg_countdown
interface seg_countdown_if;
    logic       seg_signal;
    logic [6:0] seg_out;
    logic [1:0] dig_sel;
    logic       active;

    modport master (output seg_signal, input seg_out, input dig_sel, input active);
    modport slave  (input seg_signal, output seg_out, output dig_sel, output active);
endinterface

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - BCD to active-low 7-segment decoder, codes above 9 blank
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = GLYPH_0;
            4'd1:    seg_o = GLYPH_1;
            4'd2:    seg_o = GLYPH_2;
            4'd3:    seg_o = GLYPH_3;
            4'd4:    seg_o = GLYPH_4;
            4'd5:    seg_o = GLYPH_5;
            4'd6:    seg_o = GLYPH_6;
            4'd7:    seg_o = GLYPH_7;
            4'd8:    seg_o = GLYPH_8;
            4'd9:    seg_o = GLYPH_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_countdown.sv
// rtl/seg_countdown.sv - two-phase seconds countdown on a scanned 2-digit display; SEG_LEADING_ZERO_BLANK_EN blanks a zero tens digit
module seg_countdown
    import seg_pkg::*;
#(
    parameter int TX            = 30,
    parameter int TY            = 15,
    parameter int TICKS_PER_SEC = 10,
    parameter int SCAN_DIV      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_countdown_if.slave  bus
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

    state_t          state_q, state_d;
    logic [6:0]      count_q, count_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   scan_cnt_q;
    logic            ptr_q;
    logic            sig_q;
    logic            armed_q;
    logic [6:0]      seg_out_q;
    logic [1:0]      dig_sel_q, dig_sel_d;
    logic            active_q;
    logic [3:0]      digit;
    logic [6:0]      seg_dec;
    bcd_t            bcd;
    logic            rise, fall;

    // armed_q masks edge detection for the first cycle after reset so a level
    // already present at release is only sampled, never taken as an edge
    assign rise = armed_q &  bus.seg_signal & ~sig_q;
    assign fall = armed_q & ~bus.seg_signal &  sig_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        if (rise) begin
            count_d = 7'(TX);
            presc_d = '0;
            state_d = ST_RUN;
        end else if (fall) begin
            count_d = 7'(TY);
            presc_d = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (count_q <= 7'd1) begin
                    count_d = 7'd0;
                    state_d = ST_HOLD;
                end else begin
                    count_d = count_q - 7'd1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    assign bcd = bin2bcd(count_q);

    always_comb begin
        digit     = BCD_BLANK;
        dig_sel_d = 2'b11;
        if (state_q != ST_IDLE) begin
            if (ptr_q) begin
                digit     = bcd.tens;
                dig_sel_d = 2'b01;
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if (bcd.tens == 4'd0) digit = BCD_BLANK;
`endif
            end else begin
                digit     = bcd.ones;
                dig_sel_d = 2'b10;
            end
        end
    end

    seg_decoder u_dec (
        .bcd_i (digit),
        .seg_o (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            presc_q    <= '0;
            sig_q      <= 1'b0;
            armed_q    <= 1'b0;
            scan_cnt_q <= '0;
            ptr_q      <= 1'b0;
            seg_out_q  <= SEG_BLANK;
            dig_sel_q  <= 2'b11;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            sig_q      <= bus.seg_signal;
            armed_q    <= 1'b1;
            scan_cnt_q <= (scan_cnt_q == SCAN_MAX) ? '0 : scan_cnt_q + SW'(1);
            ptr_q      <= (scan_cnt_q == SCAN_MAX) ? ~ptr_q : ptr_q;
            seg_out_q  <= seg_dec;
            dig_sel_q  <= dig_sel_d;
            active_q   <= (state_q == ST_RUN);
        end
    end

    assign bus.seg_out = seg_out_q;
    assign bus.dig_sel = dig_sel_q;
    assign bus.active  = active_q;

endmodule

// File: doc/seg_countdown.md
SEG_COUNTDOWN -- requirements
Module: seg_countdown

Interface
REQ-001 Parameter TX, default 30: X-phase countdown start value in seconds, 1..99.
REQ-002 Parameter TY, default 15: Y-phase countdown start value in seconds, 1..99.
REQ-003 Parameter TICKS_PER_SEC, default 10: clk cycles per displayed second, >=2.
REQ-004 Parameter SCAN_DIV, default 2: clk cycles per digit-scan slot, >=1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 seg_signal  input  1  phase indicator from the light controller, synchronous to clk; rising edge = X phase start, falling edge = Y phase start.
REQ-008 seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 dig_sel  output  2  digit enables, active-low; bit1 = tens, bit0 = ones; registered.
REQ-010 active  output  1  high while the countdown is running, registered.

Function
REQ-011 The block SHALL register seg_signal into seg_d every cycle; rise = seg_signal & ~seg_d, fall = ~seg_signal & seg_d.
REQ-012 The FSM SHALL have states IDLE, RUN, HOLD; reset state IDLE.
REQ-013 In any state, on rise the block SHALL set count<=TX, presc<=0, state<=RUN at the same clock edge; on fall, count<=TY likewise.
REQ-014 In RUN, presc SHALL increment each cycle and wrap from TICKS_PER_SEC-1 to 0; on the wrap cycle count SHALL decrement by 1.
REQ-015 A count value SHALL be held for exactly TICKS_PER_SEC cycles after a load or decrement.
REQ-016 When count decrements to 0, state SHALL go to HOLD; HOLD keeps count=0, presc frozen, until the next edge; count never wraps below 0.
REQ-017 An edge arriving on the same cycle as a decrement SHALL win: the load value replaces the decrement.
REQ-018 active SHALL be 1 in RUN, 0 in IDLE and HOLD, updated one cycle after the state change.
REQ-019 count SHALL be 7 bits; tens = count/10 and ones = count%10, computed combinationally without a divider (compare-subtract, count <= 99).
REQ-020 A 1-bit scan pointer SHALL toggle every SCAN_DIV cycles, free-running from reset; pointer 1 selects tens (dig_sel=2'b01), pointer 0 selects ones (dig_sel=2'b10).
REQ-021 seg_out and dig_sel SHALL reflect count and the pointer with one cycle of latency.
REQ-022 In IDLE, seg_out SHALL be 7'b1111111 and dig_sel 2'b11 (display blank); in HOLD it shows 00.

Reset
REQ-023 On rst_n low, immediately: state=IDLE, count=0, presc=0, seg_d=0, scan pointer=0, seg_out=7'b1111111, dig_sel=2'b11, active=0.
REQ-024 Reset mid-RUN SHALL discard the countdown; after release the block waits in IDLE for the next edge, and a seg_signal already high at release does not count as a rise.

Configuration
REQ-025 With SEG_LEADING_ZERO_BLANK_EN defined, the tens digit SHALL drive seg_out=7'b1111111 while tens==0 (dig_sel unchanged); without it, the tens digit shows '0'.

Structure
REQ-026 Package seg_pkg SHALL hold the FSM state encoding, the 7-segment active-low glyph constants 0-9, and the blank constant.
REQ-027 Sub-module seg_decoder (4-bit BCD in, 7-bit active-low segments out, combinational, codes >9 give blank) SHALL be instantiated once, after the digit mux.

Verification
REQ-028 Reset, then seg_signal held low for 50 cycles -> seg_out=7'h7F, dig_sel=2'b11, active=0 throughout.
REQ-029 seg_signal 0->1 -> count=30 at that edge; display digits 3,0 and active=1 one cycle later; count=29 exactly 10 cycles after the load.
REQ-030 Rise, then fall 37 cycles later -> count=15 at the fall edge, presc=0, the 30-count discarded.
REQ-031 TY=2 run to completion -> count 2,1,0 at 10-cycle spacing; state HOLD, display 00, active=0, stable 100 cycles.
REQ-032 rst_n pulsed low mid-RUN with seg_signal high -> outputs blank immediately; after release the block stays IDLE until a new 0->1.
REQ-033 count=7, SEG_LEADING_ZERO_BLANK_EN defined -> tens slot seg_out=7'h7F; undefined -> 7'b1000000 ('0').
